// File: rtl/rpn_datapath.sv
// Operand/result datapath for the RPN calculator: strobe-loaded operand and opcode
// registers, a combinational ALU with NZCV flags, result register, valid flag and op counter.
module rpn_datapath #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         Reset_n,
  input  logic [N-1:0] DataIn,
  input  logic [1:0]   OpCodeIn,
  input  logic         LoadOpA,
  input  logic         LoadOpB,
  input  logic         LoadOpCode,
  input  logic         updateRes,
  input  logic         ToDisplaySel,
  output logic [N-1:0] ToDisplay,
  output logic [3:0]   Flags,
  output logic         ResValid,
  output logic [7:0]   OpCount
);

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_OR  = 2'b10,
    OP_AND = 2'b11
  } opcode_t;

  logic [N-1:0] op_a_reg, op_b_reg;
  opcode_t      opcode_reg;
  logic [N-1:0] result_reg, result_next;
  logic [3:0]   flags_reg, flags_next;
  logic         res_valid_reg, res_valid_next;
  logic [7:0]   op_count_reg, op_count_next;

  logic [N:0]   add_full, sub_full;
  logic         alu_c, alu_v;

  // Extra top bit holds carry-out for add and borrow for sub.
  assign add_full = {1'b0, op_a_reg} + {1'b0, op_b_reg};
  assign sub_full = {1'b0, op_a_reg} - {1'b0, op_b_reg};

  always_comb begin
    result_next = '0;
    alu_c       = 1'b0;
    alu_v       = 1'b0;
    unique case (opcode_reg)
      OP_ADD: begin
        result_next = add_full[N-1:0];
        alu_c       = add_full[N];
        alu_v       = (op_a_reg[N-1] == op_b_reg[N-1]) && (result_next[N-1] != op_a_reg[N-1]);
      end
      OP_SUB: begin
        result_next = sub_full[N-1:0];
        alu_c       = ~sub_full[N];
        alu_v       = (op_a_reg[N-1] != op_b_reg[N-1]) && (result_next[N-1] != op_a_reg[N-1]);
      end
      OP_OR:   result_next = op_a_reg | op_b_reg;
      OP_AND:  result_next = op_a_reg & op_b_reg;
      default: result_next = '0;
    endcase
    flags_next = {result_next[N-1], (result_next == '0), alu_c, alu_v};
  end

  always_comb begin
    res_valid_next = res_valid_reg;
    op_count_next  = op_count_reg;
    if (updateRes) begin
      res_valid_next = 1'b1;
      // Count only the 0->1 edge of ResValid, saturating at 255.
      if (!res_valid_reg && (op_count_reg != 8'hFF))
        op_count_next = op_count_reg + 8'd1;
    end else if (LoadOpA) begin
      res_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      op_a_reg      <= '0;
      op_b_reg      <= '0;
      opcode_reg    <= OP_ADD;
      result_reg    <= '0;
      flags_reg     <= '0;
      res_valid_reg <= 1'b0;
      op_count_reg  <= '0;
    end else begin
      if (LoadOpA)    op_a_reg   <= DataIn;
      if (LoadOpB)    op_b_reg   <= DataIn;
      if (LoadOpCode) opcode_reg <= opcode_t'(OpCodeIn);
      if (updateRes) begin
        result_reg <= result_next;
        flags_reg  <= flags_next;
      end
      res_valid_reg <= res_valid_next;
      op_count_reg  <= op_count_next;
    end
  end

  assign ToDisplay = ToDisplaySel ? result_reg : DataIn;
  assign Flags     = flags_reg;
  assign ResValid  = res_valid_reg;
  assign OpCount   = op_count_reg;

endmodule

// File: tb/tb_rpn_datapath.sv
// Scoreboard bench for rpn_datapath: a behavioural model predicts each cycle's
// registered outputs, pushes them on a queue, and they are popped after the edge.
module tb_rpn_datapath;

  localparam int N = 16;

  logic         clk;
  logic         Reset_n;
  logic [N-1:0] DataIn;
  logic [1:0]   OpCodeIn;
  logic         LoadOpA, LoadOpB, LoadOpCode, updateRes, ToDisplaySel;
  logic [N-1:0] ToDisplay;
  logic [3:0]   Flags;
  logic         ResValid;
  logic [7:0]   OpCount;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] res;
    logic [3:0]  flags;
    logic        valid;
    logic [7:0]  cnt;
  } exp_t;

  exp_t sb_q[$];

  // Model state
  logic [15:0] m_a, m_b, m_res;
  logic [1:0]  m_op;
  logic [3:0]  m_flags;
  logic        m_valid;
  logic [7:0]  m_cnt;

  rpn_datapath #(.N(N)) dut (
    .clk(clk), .Reset_n(Reset_n), .DataIn(DataIn), .OpCodeIn(OpCodeIn),
    .LoadOpA(LoadOpA), .LoadOpB(LoadOpB), .LoadOpCode(LoadOpCode),
    .updateRes(updateRes), .ToDisplaySel(ToDisplaySel), .ToDisplay(ToDisplay),
    .Flags(Flags), .ResValid(ResValid), .OpCount(OpCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Integer-arithmetic reference: carry/borrow and overflow from range tests.
  task automatic alu_model(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op,
                           output logic [15:0] res, output logic [3:0] fl);
    int ua, ub, sa, sb, r, s;
    logic c, v;
    ua = int'(a); ub = int'(b);
    sa = int'($signed(a)); sb = int'($signed(b));
    c = 1'b0; v = 1'b0; r = 0;
    case (op)
      2'b00: begin r = ua + ub; s = sa + sb; c = (r > 65535); v = (s > 32767) || (s < -32768); end
      2'b01: begin r = ua - ub; s = sa - sb; c = (ua >= ub);  v = (s > 32767) || (s < -32768); end
      2'b10: r = int'(a | b);
      default: r = int'(a & b);
    endcase
    res = r[15:0];
    fl  = {res[15], (res == 16'h0), c, v};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle of control stimulus; model predicts the post-edge state.
  task automatic step(input bit la, input bit lb, input bit lo, input bit upd,
                      input logic [15:0] d, input logic [1:0] oc, input bit chk, input string tag);
    exp_t e;
    logic [15:0] r;
    logic [3:0]  f;
    DataIn = d; OpCodeIn = oc;
    LoadOpA = la; LoadOpB = lb; LoadOpCode = lo; updateRes = upd;
    if (upd) begin
      alu_model(m_a, m_b, m_op, r, f);
      m_res = r; m_flags = f;
      if (!m_valid && m_cnt != 8'd255) m_cnt = m_cnt + 8'd1;
      m_valid = 1'b1;
    end else if (la) begin
      m_valid = 1'b0;
    end
    if (la) m_a = d;
    if (lb) m_b = d;
    if (lo) m_op = oc;
    if (chk) begin
      e.res = m_res; e.flags = m_flags; e.valid = m_valid; e.cnt = m_cnt;
      sb_q.push_back(e);
    end
    tick();
    LoadOpA = 0; LoadOpB = 0; LoadOpCode = 0; updateRes = 0;
    if (chk) begin
      if (sb_q.size() == 0) begin
        check({tag, "_queue"}, 32'd0, 32'd1);
      end else begin
        e = sb_q.pop_front();
        ToDisplaySel = 1'b1;
        #1;
        check({tag, "_res"},   32'(ToDisplay), 32'(e.res));
        check({tag, "_flags"}, 32'(Flags),     32'(e.flags));
        check({tag, "_valid"}, 32'(ResValid),  32'(e.valid));
        check({tag, "_cnt"},   32'(OpCount),   32'(e.cnt));
        $display("txn %s: res=%h flags=%b valid=%0d cnt=%0d", tag, ToDisplay, Flags, ResValid, OpCount);
        ToDisplaySel = 1'b0;
      end
    end
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op,
                        input string tag);
    step(1, 0, 0, 0, a, 2'b00, 0, "");
    step(0, 1, 0, 0, b, 2'b00, 0, "");
    step(0, 0, 1, 0, 16'h0, op, 0, "");
    step(0, 0, 0, 1, 16'h0, 2'b00, 1, tag);
  endtask

  task automatic model_reset();
    m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_flags = 0; m_valid = 0; m_cnt = 0;
  endtask

  initial begin
    Reset_n = 0; DataIn = 16'h0; OpCodeIn = 0;
    LoadOpA = 0; LoadOpB = 0; LoadOpCode = 0; updateRes = 0; ToDisplaySel = 0;
    model_reset();
    repeat (2) tick();
    Reset_n = 1;
    tick();

    // Reset state
    DataIn = 16'hA5A5; #1;
    check("rst_disp", 32'(ToDisplay), 32'hA5A5);
    check("rst_flags", 32'(Flags), 32'h0);
    check("rst_valid", 32'(ResValid), 32'h0);
    check("rst_cnt", 32'(OpCount), 32'h0);

    run_op(16'h7FFF, 16'h0001, 2'b00, "add_ovf");
    run_op(16'hFFFF, 16'h0001, 2'b00, "add_wrap");
    run_op(16'd5, 16'd5, 2'b01, "sub_eq");
    step(0, 1, 0, 0, 16'd7, 2'b00, 0, "");
    step(0, 0, 0, 1, 16'h0, 2'b00, 1, "sub_borrow");
    run_op(16'h00F0, 16'h0F0F, 2'b10, "or");
    step(0, 0, 1, 0, 16'h0, 2'b11, 0, "");
    step(0, 0, 0, 1, 16'h0, 2'b00, 1, "and");
    run_op(16'h8000, 16'h0001, 2'b01, "sub_vneg");

    // Display mux is combinational in both directions
    DataIn = 16'h1234; ToDisplaySel = 1; #1;
    check("disp_res", 32'(ToDisplay), 32'(m_res));
    ToDisplaySel = 0; #1;
    check("disp_data", 32'(ToDisplay), 32'h1234);
    DataIn = 16'h4321; #1;
    check("disp_data2", 32'(ToDisplay), 32'h4321);

    // Hold updateRes high: count only once
    step(1, 0, 0, 0, 16'd3, 2'b00, 1, "loada_clr");
    step(0, 1, 1, 0, 16'd4, 2'b00, 0, "");
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 16'h0, 2'b00, 1, "hold");

    // Update and load in the same cycle: old operand used, new one next cycle
    step(0, 1, 0, 1, 16'd10, 2'b00, 1, "simul_old");
    step(0, 0, 0, 1, 16'h0, 2'b00, 1, "simul_new");
    // Update and LoadOpA together: set wins
    step(1, 0, 0, 1, 16'd1, 2'b00, 1, "simul_seta");

    // Saturation
    for (int i = 0; i < 300; i++) begin
      step(1, 0, 0, 0, 16'(i), 2'b00, 0, "");
      step(0, 0, 0, 1, 16'h0, 2'b00, 0, "");
    end
    check("sat_cnt", 32'(OpCount), 32'd255);
    step(1, 0, 0, 0, 16'd9, 2'b00, 0, "");
    step(0, 0, 0, 1, 16'h0, 2'b00, 1, "sat_more");

    // Asynchronous reset between edges with updateRes high
    updateRes = 1; DataIn = 16'hBEEF;
    #2 Reset_n = 0;
    #1;
    check("arst_flags", 32'(Flags), 32'h0);
    check("arst_valid", 32'(ResValid), 32'h0);
    check("arst_cnt", 32'(OpCount), 32'h0);
    ToDisplaySel = 1; #1;
    check("arst_res", 32'(ToDisplay), 32'h0);
    ToDisplaySel = 0; #1;
    check("arst_disp", 32'(ToDisplay), 32'hBEEF);
    updateRes = 0;
    model_reset();
    tick();
    Reset_n = 1;
    repeat (3) tick();
    check("post_flags", 32'(Flags), 32'h0);
    check("post_valid", 32'(ResValid), 32'h0);
    check("post_cnt", 32'(OpCount), 32'h0);
    // Operands were cleared: 0+0 gives Z only
    step(0, 0, 0, 1, 16'h0, 2'b00, 1, "post_op");

    if (sb_q.size() != 0) check("queue_left", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
